// File: rtl/config_menu.sv
// ---------------------------------------------------------------------------
// config_menu
//   Settings-menu controller. After reset it paints the twelve option values
//   into the tile buffer (one write per cycle, busy_out high), then waits in
//   IDLE for single-cycle button pulses that move the cursor, step the value
//   under the cursor, or launch the game from the START entry (pointer 12).
//
// Configuration macro:
//   CONFIG_MENU_PTR_WRAP_EN  defined   -> cursor wraps (0 up -> 12, 12 down -> 0)
//                            undefined -> cursor saturates at 0 and 12
//
// Parameters:
//   NUM_VALUES          settings per option, legal 2..10
//
// Ports:
//   clk_in              system clock, rising edge
//   rst_n_in            asynchronous active-low reset
//   btn_up_in           pulse: cursor up (ptr-1)
//   btn_down_in         pulse: cursor down (ptr+1)
//   btn_left_in         pulse: decrement selected value (mod NUM_VALUES)
//   btn_right_in        pulse: increment selected value (mod NUM_VALUES)
//   btn_select_in       pulse: activate entry (START when ptr == 12)
//   ptr_index_out       cursor index 0..12
//   config_values_out   option i value at bits [4i+3:4i]
//   start_out           one-cycle game launch pulse
//   busy_out            high while the initial paint runs
//   buf_write_en_out    tile-buffer write enable
//   buf_write_addr_out  tile-buffer address (40*row + col)
//   buf_write_data_out  tile code (8'h30 + value)
// ---------------------------------------------------------------------------
module config_menu #(
    parameter int NUM_VALUES = 10
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        btn_up_in,
    input  logic        btn_down_in,
    input  logic        btn_left_in,
    input  logic        btn_right_in,
    input  logic        btn_select_in,
    output logic [3:0]  ptr_index_out,
    output logic [47:0] config_values_out,
    output logic        start_out,
    output logic        busy_out,
    output logic        buf_write_en_out,
    output logic [9:0]  buf_write_addr_out,
    output logic [7:0]  buf_write_data_out
);

    localparam int         LP_NUM_OPTS = 12;
    localparam logic [3:0] LP_PTR_MAX  = 4'd12;
    localparam logic [3:0] LP_OPT_LAST = 4'd11;
    localparam logic [3:0] LP_VAL_LAST = 4'(NUM_VALUES - 1);

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_paint_cnt;
    logic [3:0]  r_ptr;
    logic [3:0]  r_values [LP_NUM_OPTS];
    logic        r_start;
    logic        r_busy;
    logic        r_wr_en;
    logic [9:0]  r_wr_addr;
    logic [7:0]  r_wr_data;

    logic        w_ptr_is_opt;
    logic [3:0]  w_sel_val;
    logic [3:0]  w_val_inc;
    logic [3:0]  w_val_dec;

    // Options 0..7 sit in the left column (col 10), 8..11 in the right
    // column (col 30); both columns start on row 3 with one blank row between
    // entries. For idx < 12, idx[3] selects the column and idx[2:0] is the
    // position within it.
    function automatic logic [9:0] f_addr(input logic [3:0] idx);
        logic [9:0] row;
        logic [9:0] col;
        row = 10'd3 + {6'd0, idx[2:0], 1'b0};
        col = idx[3] ? 10'd30 : 10'd10;
        return (row * 10'd40) + col;
    endfunction

    function automatic logic [7:0] f_tile(input logic [3:0] val);
        return 8'h30 + {4'd0, val};
    endfunction

    function automatic logic [3:0] f_val_inc(input logic [3:0] val);
        return (val >= LP_VAL_LAST) ? 4'd0 : val + 4'd1;
    endfunction

    function automatic logic [3:0] f_val_dec(input logic [3:0] val);
        return (val == 4'd0) ? LP_VAL_LAST : val - 4'd1;
    endfunction

    function automatic logic [3:0] f_ptr_up(input logic [3:0] ptr);
        if (ptr == 4'd0) begin
`ifdef CONFIG_MENU_PTR_WRAP_EN
            return LP_PTR_MAX;
`else
            return 4'd0;
`endif
        end
        return ptr - 4'd1;
    endfunction

    function automatic logic [3:0] f_ptr_down(input logic [3:0] ptr);
        if (ptr >= LP_PTR_MAX) begin
`ifdef CONFIG_MENU_PTR_WRAP_EN
            return 4'd0;
`else
            return LP_PTR_MAX;
`endif
        end
        return ptr + 4'd1;
    endfunction

    // Value currently under the cursor; pointer 12 (START) has no value.
    always_comb begin
        w_ptr_is_opt = (r_ptr < LP_PTR_MAX);
        w_sel_val    = 4'd0;
        if (w_ptr_is_opt) begin
            w_sel_val = r_values[r_ptr];
        end
        w_val_inc = f_val_inc(w_sel_val);
        w_val_dec = f_val_dec(w_sel_val);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_INIT;
            r_paint_cnt <= 4'd0;
            r_ptr       <= 4'd0;
            for (int i = 0; i < LP_NUM_OPTS; i++) begin
                r_values[i] <= 4'd0;
            end
            r_start     <= 1'b0;
            r_busy      <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 10'd0;
            r_wr_data   <= 8'd0;
        end else begin
            // Pulsed outputs default low; addr/data hold their last value.
            r_wr_en <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    // Buttons are deliberately not looked at here.
                    r_busy    <= 1'b1;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= f_addr(r_paint_cnt);
                    r_wr_data <= f_tile(r_values[r_paint_cnt]);
                    if (r_paint_cnt == LP_OPT_LAST) begin
                        r_paint_cnt <= 4'd0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_paint_cnt <= r_paint_cnt + 4'd1;
                    end
                end
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    // Fixed priority: one button per cycle, the rest dropped.
                    if (btn_up_in) begin
                        r_ptr <= f_ptr_up(r_ptr);
                    end else if (btn_down_in) begin
                        r_ptr <= f_ptr_down(r_ptr);
                    end else if (btn_left_in) begin
                        if (w_ptr_is_opt) begin
                            r_values[r_ptr] <= w_val_dec;
                            r_wr_en         <= 1'b1;
                            r_wr_addr       <= f_addr(r_ptr);
                            r_wr_data       <= f_tile(w_val_dec);
                        end
                    end else if (btn_right_in) begin
                        if (w_ptr_is_opt) begin
                            r_values[r_ptr] <= w_val_inc;
                            r_wr_en         <= 1'b1;
                            r_wr_addr       <= f_addr(r_ptr);
                            r_wr_data       <= f_tile(w_val_inc);
                        end
                    end else if (btn_select_in) begin
                        if (r_ptr == LP_PTR_MAX) begin
                            r_start <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    always_comb begin
        config_values_out = '0;
        for (int i = 0; i < LP_NUM_OPTS; i++) begin
            config_values_out[4*i +: 4] = r_values[i];
        end
    end

    assign ptr_index_out      = r_ptr;
    assign start_out          = r_start;
    assign busy_out           = r_busy;
    assign buf_write_en_out   = r_wr_en;
    assign buf_write_addr_out = r_wr_addr;
    assign buf_write_data_out = r_wr_data;

endmodule

// File: tb/tb_config_menu.sv
// ---------------------------------------------------------------------------
// tb_config_menu
//   Directed bench for config_menu (NUM_VALUES = 10). Expected tile-buffer
//   writes are pushed to a queue as stimulus is applied; a monitor pops and
//   compares every write the DUT issues.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_config_menu;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        btn_up_in, btn_down_in, btn_left_in, btn_right_in, btn_select_in;
    logic [3:0]  ptr_index_out;
    logic [47:0] config_values_out;
    logic        start_out, busy_out, buf_write_en_out;
    logic [9:0]  buf_write_addr_out;
    logic [7:0]  buf_write_data_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [17:0] exp_q [$];

    config_menu #(.NUM_VALUES(10)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .btn_up_in         (btn_up_in),
        .btn_down_in       (btn_down_in),
        .btn_left_in       (btn_left_in),
        .btn_right_in      (btn_right_in),
        .btn_select_in     (btn_select_in),
        .ptr_index_out     (ptr_index_out),
        .config_values_out (config_values_out),
        .start_out         (start_out),
        .busy_out          (busy_out),
        .buf_write_en_out  (buf_write_en_out),
        .buf_write_addr_out(buf_write_addr_out),
        .buf_write_data_out(buf_write_data_out)
    );

    always #5 clk_in = ~clk_in;

    // Write monitor / scoreboard.
    always @(negedge clk_in) begin
        if (rst_n_in === 1'b1 && buf_write_en_out === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_write: observed addr=%0d data=%h, required no write",
                       buf_write_addr_out, buf_write_data_out);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                assert ({buf_write_addr_out, buf_write_data_out} === e) else begin
                    n_fail++;
                    $error("FAIL write: observed addr=%0d data=%h, required addr=%0d data=%h",
                           buf_write_addr_out, buf_write_data_out, e[17:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    // which: 0 up, 1 down, 2 left, 3 right, 4 select
    task automatic press(input int which);
        case (which)
            0: btn_up_in = 1'b1;
            1: btn_down_in = 1'b1;
            2: btn_left_in = 1'b1;
            3: btn_right_in = 1'b1;
            default: btn_select_in = 1'b1;
        endcase
        tick();
        btn_up_in = 1'b0; btn_down_in = 1'b0; btn_left_in = 1'b0;
        btn_right_in = 1'b0; btn_select_in = 1'b0;
    endtask

    task automatic push_paint();
        int a;
        for (int i = 0; i < 12; i++) begin
            a = (i < 8) ? (130 + 80 * i) : (150 + 80 * (i - 8));
            exp_q.push_back({10'(a), 8'h30});
        end
    endtask

    // Twelve consecutive paint writes, busy high throughout, then idle.
    task automatic run_paint(input string tag, input bit poke_buttons);
        for (int i = 0; i < 12; i++) begin
            if (poke_buttons && i == 3) begin
                btn_down_in = 1'b1; btn_right_in = 1'b1; btn_select_in = 1'b1;
            end
            tick();
            btn_down_in = 1'b0; btn_right_in = 1'b0; btn_select_in = 1'b0;
            check({tag, "_wr_en"}, 48'(buf_write_en_out), 48'd1);
            check({tag, "_busy"}, 48'(busy_out), 48'd1);
        end
        tick();
        check({tag, "_busy_done"}, 48'(busy_out), 48'd0);
        check({tag, "_wr_en_done"}, 48'(buf_write_en_out), 48'd0);
        check({tag, "_queue_empty"}, 48'(exp_q.size()), 48'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_ptr;
        rst_n_in = 1'b0;
        btn_up_in = 1'b0; btn_down_in = 1'b0; btn_left_in = 1'b0;
        btn_right_in = 1'b0; btn_select_in = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_ptr", 48'(ptr_index_out), 48'd0);
        check("rst_values", config_values_out, 48'd0);
        check("rst_start", 48'(start_out), 48'd0);
        check("rst_wr_en", 48'(buf_write_en_out), 48'd0);
        check("rst_addr", 48'(buf_write_addr_out), 48'd0);
        check("rst_data", 48'(buf_write_data_out), 48'd0);
        check("rst_busy", 48'(busy_out), 48'd1);

        // Initial paint, with button pulses during INIT that must be ignored
        push_paint();
        rst_n_in = 1'b1;
        run_paint("paint", 1'b1);
        check("init_btn_ptr", 48'(ptr_index_out), 48'd0);
        check("init_btn_values", config_values_out, 48'd0);

        // ptr=9, right x3 back to back
        for (int i = 0; i < 9; i++) press(1);
        check("ptr9", 48'(ptr_index_out), 48'd9);
        exp_q.push_back({10'd230, 8'h31});
        exp_q.push_back({10'd230, 8'h32});
        exp_q.push_back({10'd230, 8'h33});
        btn_right_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("right_b2b_en", 48'(buf_write_en_out), 48'd1);
        end
        btn_right_in = 1'b0;
        tick();
        check("right_b2b_en_off", 48'(buf_write_en_out), 48'd0);
        check("val9", 48'(config_values_out[39:36]), 48'd3);
        check("right_queue", 48'(exp_q.size()), 48'd0);

        // ptr=0, left at value 0 wraps to 9
        for (int i = 0; i < 9; i++) press(0);
        check("ptr0", 48'(ptr_index_out), 48'd0);
        exp_q.push_back({10'd130, 8'h39});
        press(2);
        check("left_wr_en", 48'(buf_write_en_out), 48'd1);
        check("val0_wrap", 48'(config_values_out[3:0]), 48'd9);
        check("left_queue", 48'(exp_q.size()), 48'd0);

        // Pointer end behaviour
        press(0);
`ifdef CONFIG_MENU_PTR_WRAP_EN
        exp_ptr = 4'd12;
`else
        exp_ptr = 4'd0;
`endif
        check("ptr_up_at_0", 48'(ptr_index_out), 48'(exp_ptr));
        while (ptr_index_out != 4'd12 && exp_ptr == 4'd0) press(1);
        check("ptr_at_12", 48'(ptr_index_out), 48'd12);
        press(1);
`ifdef CONFIG_MENU_PTR_WRAP_EN
        check("ptr_down_at_12", 48'(ptr_index_out), 48'd0);
        press(0);
`else
        check("ptr_down_at_12", 48'(ptr_index_out), 48'd12);
`endif

        // Left/right on START are no-ops
        press(3);
        press(2);
        check("start_lr_en", 48'(buf_write_en_out), 48'd0);
        check("start_lr_values", config_values_out, 48'h003000000009);

        // Select on START: one-cycle pulse
        press(4);
        check("start_pulse", 48'(start_out), 48'd1);
        tick();
        check("start_pulse_end", 48'(start_out), 48'd0);

        // up+right together at ptr 5: only up is taken
        for (int i = 0; i < 7; i++) press(0);
        check("ptr5", 48'(ptr_index_out), 48'd5);
        btn_up_in = 1'b1; btn_right_in = 1'b1;
        tick();
        btn_up_in = 1'b0; btn_right_in = 1'b0;
        check("prio_ptr", 48'(ptr_index_out), 48'd4);
        check("prio_no_write", 48'(buf_write_en_out), 48'd0);
        check("prio_values", config_values_out, 48'h003000000009);

        // Select on an option does nothing
        press(4);
        check("select_opt_start", 48'(start_out), 48'd0);

        // Give option 4 a value, then reset mid-paint
        exp_q.push_back({10'd450, 8'h31});
        press(3);
        check("val4", 48'(config_values_out[19:16]), 48'd1);
        rst_n_in = 1'b0;
        #1;
        check("rst2_values", config_values_out, 48'd0);
        check("rst2_ptr", 48'(ptr_index_out), 48'd0);
        tick();
        push_paint();
        rst_n_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("mid_init_en", 48'(buf_write_en_out), 48'd1);
        check("mid_init_addr", 48'(buf_write_addr_out), 48'd450);
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_en", 48'(buf_write_en_out), 48'd0);
        check("mid_rst_addr", 48'(buf_write_addr_out), 48'd0);
        check("mid_rst_data", 48'(buf_write_data_out), 48'd0);
        check("mid_rst_busy", 48'(busy_out), 48'd1);
        exp_q.delete();
        tick();
        push_paint();
        rst_n_in = 1'b1;
        run_paint("repaint", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/config_menu.md
CONFIG_MENU -- requirements
Module: config_menu

Interface
REQ-001 SHALL have parameter NUM_VALUES, default 10, the number of settings each option cycles through (legal range 2..10).
REQ-002 SHALL have port clk_in, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port btn_up_in, input, 1 bit: single-cycle pulse that moves the pointer up.
REQ-005 SHALL have port btn_down_in, input, 1 bit: single-cycle pulse that moves the pointer down.
REQ-006 SHALL have port btn_left_in, input, 1 bit: single-cycle pulse that decrements the selected option's value.
REQ-007 SHALL have port btn_right_in, input, 1 bit: single-cycle pulse that increments the selected option's value.
REQ-008 SHALL have port btn_select_in, input, 1 bit: single-cycle pulse that activates the selected entry.
REQ-009 SHALL have port ptr_index_out, output, 4 bits: cursor index 0..12, consumed by config_video.
REQ-010 SHALL have port config_values_out, output, 48 bits: option i value at bits [4i+3:4i], for i = 0..11.
REQ-011 SHALL have port start_out, output, 1 bit: one-cycle pulse that launches the game.
REQ-012 SHALL have port busy_out, output, 1 bit: high while the initial paint is running.
REQ-013 SHALL have port buf_write_en_out, output, 1 bit: tile-buffer write enable.
REQ-014 SHALL have port buf_write_addr_out, output, 10 bits: tile-buffer address, computed as 40*row + col.
REQ-015 SHALL have port buf_write_data_out, output, 8 bits: tile code to write.

Function
REQ-016 SHALL have exactly two states: INIT and IDLE; all outputs are registered.
REQ-017 SHALL place options 0..7 at row 3+2i, col 10, and options 8..11 at row 3+2(i-8), col 30.
REQ-018 SHALL encode a displayed value v as tile code 8'h30+v.
REQ-019 SHALL, in INIT, issue one write per cycle for option 0 through option 11 in order, with busy_out=1, then enter IDLE on the cycle after the write for option 11.
REQ-020 SHALL ignore all button pulses while in INIT.
REQ-021 SHALL, in IDLE, accept at most one button per cycle, with priority up > down > left > right > select; lower-priority pulses in the same cycle are dropped.
REQ-022 SHALL handle up as ptr-1 and down as ptr+1; behaviour at the ends (ptr 0 up, ptr 12 down) is set by the configuration macro.
REQ-023 SHALL, on left/right with ptr 0..11, update value[ptr] modulo NUM_VALUES at the accepting edge (right at NUM_VALUES-1 gives 0; left at 0 gives NUM_VALUES-1).
REQ-024 SHALL, on the same edge as REQ-023, register buf_write_en_out=1 with the address and data for the new value, held for exactly one cycle (latency 1 cycle from pulse to write).
REQ-025 SHALL treat left/right with ptr=12 as no-op: no write, no value change.
REQ-026 SHALL, on select with ptr=12, pulse start_out for exactly one cycle; select with ptr 0..11 is a no-op.
REQ-027 SHALL keep buf_write_en_out=0 whenever no write is issued; addr/data are don't-care then but hold their last value.
REQ-028 SHALL let back-to-back accepted left/right pulses produce back-to-back writes with no stall.

Reset
REQ-029 SHALL, while rst_n_in=0, set ptr_index_out=0, all values 0, start_out=0, buf_write_en_out=0, addr=0, data=0, busy_out=1, state=INIT, paint counter=0.
REQ-030 SHALL restart the paint from option 0 if reset is asserted mid-INIT; the first write occurs in the first cycle after release.

Configuration
REQ-031 SHALL, when CONFIG_MENU_PTR_WRAP_EN is defined, wrap the pointer: up at 0 gives 12, down at 12 gives 0.
REQ-032 SHALL, when CONFIG_MENU_PTR_WRAP_EN is undefined, saturate the pointer: up at 0 stays 0, down at 12 stays 12.

Verification
REQ-033 SHALL cover reset release: expect 12 consecutive writes, addr 130,210,290,...,690,150,230,310,390, data 8'h30 each, busy_out falling after the last write.
REQ-034 SHALL cover ptr=9, btn_right x3 (NUM_VALUES=10): expect writes to addr 230 with data 8'h31, 8'h32, 8'h33 on consecutive cycles, and config_values_out[39:36]=3.
REQ-035 SHALL cover ptr=0, value 0, btn_left: expect value 9 and a write to addr 130 with data 8'h39.
REQ-036 SHALL cover ptr=0, btn_up: expect ptr 12 with the macro defined and ptr 0 without; then ptr=12, btn_select gives start_out high for exactly 1 cycle.
REQ-037 SHALL cover btn_up and btn_right in the same cycle at ptr=5: expect ptr 4 and no write; also pulses during INIT are ignored.
REQ-038 SHALL cover rst_n_in asserted after the 5th INIT write: expect outputs to reset immediately, then a full 12-write paint restarting at addr 130.
